// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/busy/done handshake bundle between a controller and serial_adder.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             busy;
    logic             done;

    modport master (
        output start, A, B, Cin,
        input  S, Cout, busy, done
    );

    modport slave (
        input  start, A, B, Cin,
        output S, Cout, busy, done
    );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder reusing one full-adder slice per clock.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_adder_if.slave     bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             p, g0, g1, sum_bit, co;
    logic [WIDTH:0]   rs_ext;
    logic [WIDTH-1:0] rs_shift;
    logic             last;

    // Full-adder slice: propagate/generate from the operand bits, then fold in the carry.
    half_adder u_ha0 (.a(ra_q[0]), .b(rb_q[0]), .s(p),       .c(g0));
    half_adder u_ha1 (.a(p),       .b(c_q),     .s(sum_bit), .c(g1));
    assign co = g0 | g1;

    // New sum bit enters at the top so that after WIDTH shifts bit 0 sits at rs[0];
    // the widened vector keeps this legal for WIDTH=1.
    assign rs_ext   = {sum_bit, rs_q};
    assign rs_shift = rs_ext[WIDTH:1];
    assign last     = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rs_d    = rs_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ra_d    = bus.A;
                    rb_d    = bus.B;
                    c_d     = bus.Cin;
                    cnt_d   = '0;
                    rs_d    = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                rs_d  = rs_shift;
                c_d   = co;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    s_d     = rs_shift;
                    cout_d  = co;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rs_q    <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rs_q    <= rs_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.S    = s_q;
    assign bus.Cout = cout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
